// File: rtl/bus_op_accumulator_if.sv
// Handshake bundle between an operand producer, the accumulator and a stallable consumer.
`timescale 1ns/1ps
interface bus_op_accumulator_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_bus;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_bus;
   logic             out_flag;

   modport master (
      output in_valid, in_op, in_bus, out_ready,
      input  in_ready, out_valid, out_bus, out_flag
   );

   modport slave (
      input  in_valid, in_op, in_bus, out_ready,
      output in_ready, out_valid, out_bus, out_flag
   );
endinterface

// File: rtl/bus_op_accumulator.sv
// Opcode-driven WIDTH-bit accumulator; each accepted op queues {flag, result} into a DEPTH-entry FIFO.
`timescale 1ns/1ps
module bus_op_accumulator #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter bit SAT   = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   bus_op_accumulator_if.slave  bus,
   output logic [WIDTH-1:0]     acc,
   output logic [7:0]           flag_cnt
);

   typedef enum logic [2:0] {
      OP_LOAD = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4,
      OP_XOR  = 3'd5,
      OP_CLR  = 3'd6,
      OP_NOP  = 3'd7
   } op_e;

   typedef struct packed {
      logic             flag;
      logic [WIDTH-1:0] data;
   } entry_t;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   op_e              op;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] result;
   logic             flag;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign op    = op_e'(bus.in_op);
   assign sum   = {1'b0, acc} + {1'b0, bus.in_bus};
   assign diff  = {1'b0, acc} - {1'b0, bus.in_bus};

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Ready comes from registered occupancy only, so a pop never bypasses into a same-cycle push.
   assign bus.in_ready = rst & ~full;
   assign push         = bus.in_valid & bus.in_ready;
   assign pop          = bus.out_ready & ~empty;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      result = acc;
      flag   = 1'b0;
      unique case (op)
         OP_LOAD: result = bus.in_bus;
         OP_ADD: begin
            flag   = sum[WIDTH];
            result = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
         end
         OP_SUB: begin
            flag   = diff[WIDTH];
            result = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
         end
         OP_AND:  result = acc & bus.in_bus;
         OP_OR:   result = acc | bus.in_bus;
         OP_XOR:  result = acc ^ bus.in_bus;
         OP_CLR:  result = '0;
         OP_NOP:  result = acc;
         default: result = acc;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc      <= '0;
         flag_cnt <= '0;
      end else if (push) begin
         acc <= result;
         if (flag && (flag_cnt != 8'hFF)) begin
            flag_cnt <= flag_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; stale words are unreachable because the head is masked while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{flag: flag, data: result};
      end
   end

   assign head          = mem[rd_ptr];
   assign bus.out_valid = ~empty;
   assign bus.out_bus   = empty ? '0 : head.data;
   assign bus.out_flag  = empty ? 1'b0 : head.flag;

endmodule

// File: tb/tb_bus_op_accumulator.sv
// Directed scoreboard bench: drivers queue expected {bus, flag}; per-instance monitors pop on each output beat.
`timescale 1ns/1ps
module tb_bus_op_accumulator;

   localparam int W = 16;
   localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                          OR_  = 3'd4, XOR_ = 3'd5, CLR = 3'd6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bus_op_accumulator_if #(.WIDTH(W)) ifc0 ();
   bus_op_accumulator_if #(.WIDTH(W)) ifc1 ();
   logic [W-1:0] acc0, acc1;
   logic [7:0]   fc0, fc1;

   bus_op_accumulator #(.WIDTH(W), .DEPTH(4), .SAT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(ifc0), .acc(acc0), .flag_cnt(fc0)
   );
   bus_op_accumulator #(.WIDTH(W), .DEPTH(4), .SAT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(ifc1), .acc(acc1), .flag_cnt(fc1)
   );

   typedef struct {
      logic [W-1:0] bus;
      logic         flag;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && ifc0.out_valid && ifc0.out_ready) begin
         if (q0.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut0 unexpected output: got 0x%0h, expected none", ifc0.out_bus);
         end else begin
            e = q0.pop_front();
            check("dut0 out_bus", ifc0.out_bus, e.bus);
            check("dut0 out_flag", ifc0.out_flag, e.flag);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst && ifc1.out_valid && ifc1.out_ready) begin
         if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut1 unexpected output: got 0x%0h, expected none", ifc1.out_bus);
         end else begin
            e = q1.pop_front();
            check("dut1 out_bus", ifc1.out_bus, e.bus);
            check("dut1 out_flag", ifc1.out_flag, e.flag);
         end
      end
   end

   function automatic logic ready_of(input int sel);
      return (sel == 0) ? ifc0.in_ready : ifc1.in_ready;
   endfunction

   // Called just after a rising edge; returns just after the edge that accepted the op.
   task automatic send(input int sel, input logic [2:0] op, input logic [W-1:0] data,
                       input logic [W-1:0] eb, input logic ef, input bit push_exp);
      int n;
      exp_t e;
      if (sel == 0) begin
         ifc0.in_valid = 1'b1; ifc0.in_op = op; ifc0.in_bus = data;
      end else begin
         ifc1.in_valid = 1'b1; ifc1.in_op = op; ifc1.in_bus = data;
      end
      if (push_exp) begin
         e.bus = eb; e.flag = ef;
         if (sel == 0) q0.push_back(e); else q1.push_back(e);
      end
      n = 0;
      while (!ready_of(sel) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         vectors++;
         miscompares++;
         $display("FAIL accept timeout on dut%0d: got in_ready 0, expected 1", sel);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int cycles);
      ifc0.in_valid = 1'b0;
      ifc1.in_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      ifc0.in_valid = 1'b0; ifc0.in_op = LOAD; ifc0.in_bus = '0; ifc0.out_ready = 1'b1;
      ifc1.in_valid = 1'b0; ifc1.in_op = LOAD; ifc1.in_bus = '0; ifc1.out_ready = 1'b1;

      // Reset state
      #3;
      check("reset in_ready", ifc0.in_ready, 0);
      check("reset out_valid", ifc0.out_valid, 0);
      check("reset out_bus", ifc0.out_bus, 0);
      check("reset out_flag", ifc0.out_flag, 0);
      check("reset acc", acc0, 0);
      check("reset flag_cnt", fc0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("in_ready after release", ifc0.in_ready, 1);
      @(posedge clk); #1;

      // Load then add, with first-result latency
      send(0, LOAD, 16'h1234, 16'h1234, 1'b0, 1'b1);
      check("load acc", acc0, 16'h1234);
      check("load out_valid", ifc0.out_valid, 1);
      check("load out_bus", ifc0.out_bus, 16'h1234);
      send(0, ADD, 16'h0001, 16'h1235, 1'b0, 1'b1);
      check("add acc", acc0, 16'h1235);
      idle(1);

      // Wrap-around carry and borrow
      send(0, LOAD, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      send(0, ADD,  16'h0002, 16'h0001, 1'b1, 1'b1);
      send(0, CLR,  16'h0000, 16'h0000, 1'b0, 1'b1);
      send(0, SUB,  16'h0001, 16'hFFFF, 1'b1, 1'b1);
      idle(1);
      check("wrap acc", acc0, 16'hFFFF);
      check("wrap flag_cnt", fc0, 2);

      // Saturating instance
      send(1, LOAD, 16'hFFF0, 16'hFFF0, 1'b0, 1'b1);
      send(1, ADD,  16'h0100, 16'hFFFF, 1'b1, 1'b1);
      check("sat add acc", acc1, 16'hFFFF);
      send(1, LOAD, 16'h0005, 16'h0005, 1'b0, 1'b1);
      send(1, SUB,  16'h0010, 16'h0000, 1'b1, 1'b1);
      idle(1);
      check("sat sub acc", acc1, 16'h0000);
      check("sat flag_cnt", fc1, 2);

      // Bitwise ops
      send(0, LOAD, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1);
      send(0, XOR_, 16'hFFFF, 16'hF0F0, 1'b0, 1'b1);
      send(0, AND_, 16'hFF00, 16'hF000, 1'b0, 1'b1);
      send(0, OR_,  16'h000F, 16'hF00F, 1'b0, 1'b1);
      check("or acc", acc0, 16'hF00F);
      send(0, CLR,  16'h1234, 16'h0000, 1'b0, 1'b1);
      idle(3);
      check("logic flag_cnt", fc0, 2);

      // Backpressure: fill, hold the fifth, then drain
      ifc0.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         send(0, LOAD, W'(i), W'(i), 1'b0, 1'b1);
      end
      check("full in_ready", ifc0.in_ready, 0);
      check("full head", ifc0.out_bus, 16'h0001);
      ifc0.in_valid = 1'b1; ifc0.in_op = LOAD; ifc0.in_bus = 16'h0005;
      q0.push_back('{bus: 16'h0005, flag: 1'b0});
      repeat (3) @(posedge clk);
      #1;
      check("held in_ready", ifc0.in_ready, 0);
      check("held acc", acc0, 16'h0004);
      ifc0.out_ready = 1'b1;
      @(posedge clk); #1;
      check("after pop in_ready", ifc0.in_ready, 1);
      check("after pop acc", acc0, 16'h0004);
      @(posedge clk); #1;
      check("fifth accepted acc", acc0, 16'h0005);
      idle(6);
      check("drained out_valid", ifc0.out_valid, 0);

      // Asynchronous reset with queued entries
      ifc0.out_ready = 1'b0;
      send(0, LOAD, 16'h0011, 16'h0, 1'b0, 1'b0);
      send(0, ADD,  16'hFFFF, 16'h0, 1'b0, 1'b0);
      send(0, OR_,  16'h0300, 16'h0, 1'b0, 1'b0);
      ifc0.in_valid = 1'b0;
      check("pre-reset out_valid", ifc0.out_valid, 1);
      check("pre-reset flag_cnt", fc0, 3);
      #3 rst = 1'b0;
      #1;
      check("mid reset out_valid", ifc0.out_valid, 0);
      check("mid reset acc", acc0, 0);
      check("mid reset flag_cnt", fc0, 0);
      check("mid reset in_ready", ifc0.in_ready, 0);
      check("mid reset out_bus", ifc0.out_bus, 0);
      @(posedge clk); #1;
      check("held reset in_ready", ifc0.in_ready, 0);
      #3 rst = 1'b1;
      #1;
      check("post reset in_ready", ifc0.in_ready, 1);
      check("post reset out_valid", ifc0.out_valid, 0);
      @(posedge clk); #1;
      ifc0.out_ready = 1'b1;
      send(0, LOAD, 16'h00AA, 16'h00AA, 1'b0, 1'b1);
      check("post reset acc", acc0, 16'h00AA);
      idle(2);

      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
         @(posedge clk);
         n++;
      end
      if (n >= 50) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
